// File: rtl/lbread.sv
// lbread: elastic read-side buffer between a line buffer and a pixel consumer.
// Collects pixels into a DEPTH-entry circular store and releases them in
// uninterrupted bursts of LINE pixels, marking the final pixel with out_last.
// Optional feature: define LBREAD_OVF_EN to add the sticky overflow output.
//
// Handshake: a pixel moves to the consumer on every rising edge where
// out_valid and out_ready are both 1; out_valid never depends on out_ready.
// The upstream side has no backpressure: in_valid pixels are taken when
// there is room (or a pop frees a slot that cycle), and dropped otherwise.
// stall is only an advisory request to upstream.
module lbread #(
    parameter int DEPTH    = 16,
    parameter int LINE     = 8,
    parameter int STALL_TH = DEPTH - 2
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        stall,
    input  logic        flush,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
`ifdef LBREAD_OVF_EN
    output logic        overflow,
`endif
    output logic [0:0]  fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(LINE);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] LINE_C   = CW'(LINE);
    localparam logic [CW-1:0] STALL_C  = CW'(STALL_TH);
    localparam logic [LW-1:0] LAST_IDX = LW'(LINE - 1);

    localparam logic [0:0] ST_WAIT = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [LW-1:0] lidx;
    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic          push;
    logic          pop;

    // Output decode and handshake qualifiers; a pop into a full store frees the slot being written.
    always_comb begin
        out_valid = (state == ST_SEND);
        pop       = out_valid & out_ready;
        push      = in_valid & ((cnt != DEPTH_C) | pop);
        out_last  = out_valid & (lidx == LAST_IDX);
        out_data  = out_valid ? mem[rptr] : 16'h0;
        stall     = (cnt >= STALL_C);
        cnt_nxt   = cnt + CW'(push) - CW'(pop);
        fsm_state = state;
    end

    // Line framing: start once a full line is stored, and only reconsider at the end of a line.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT: if (cnt >= LINE_C) state_nxt = ST_SEND;
            default: if (pop && out_last && (cnt_nxt < LINE_C)) state_nxt = ST_WAIT;
        endcase
    end

    // Pointers, occupancy, line index and state; flush wins over any same-cycle push or pop.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            lidx  <= '0;
            state <= ST_WAIT;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            lidx  <= '0;
            state <= ST_WAIT;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) begin
                rptr <= rptr + 1'b1;
                lidx <= lidx + 1'b1;
            end
            cnt   <= cnt_nxt;
            state <= state_nxt;
        end
    end

    // Pixel storage: contents are never cleared, only the pointers are.
    always_ff @(posedge CLK) begin
        if (push && !flush) mem[wptr] <= in_data;
    end

`ifdef LBREAD_OVF_EN
    // Sticky record of any pixel lost to a full store with no pop in the same cycle.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN)                          overflow <= 1'b0;
        else if (flush)                       overflow <= 1'b0;
        else if (in_valid && !push)           overflow <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_lbread.sv
// Bench for lbread: a negedge monitor keeps an occupancy/line model and an
// expected-pixel queue; a vector table covers fill levels, and hand-written
// sequences cover latency, stall release, full push+pop, flush and reset.
module tb_lbread;

    localparam int DEPTH    = 16;
    localparam int LINE     = 8;
    localparam int STALL_TH = 14;

    logic        CLK       = 1'b0;
    logic        RESETN    = 1'b0;
    logic [15:0] in_data   = 16'h0;
    logic        in_valid  = 1'b0;
    logic        flush     = 1'b0;
    logic        out_ready = 1'b0;
    logic        stall;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic [0:0]  fsm_state;
`ifdef LBREAD_OVF_EN
    logic        overflow;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pop = 0;
    int          mdl_cnt = 0;
    int          mdl_lidx = 0;
    logic        mdl_ovf = 1'b0;
    logic [15:0] next_px = 16'h1;
    logic [15:0] exp_q[$];

    typedef struct {
        int   n_push;
        logic exp_stall;
        logic exp_valid;
        int   exp_out;
    } vec_t;

    vec_t vecs[6];

    lbread #(.DEPTH(DEPTH), .LINE(LINE), .STALL_TH(STALL_TH)) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .stall     (stall),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
`ifdef LBREAD_OVF_EN
        .overflow  (overflow),
`endif
        .fsm_state (fsm_state)
    );

    // Clock.
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor/scoreboard: inputs are stable at negedge, so what is seen here happens at the next posedge.
    always @(negedge CLK) begin : mon
        logic [15:0] e;
        logic        p;
        if (!RESETN) begin
            check("rst_valid", out_valid, 0);
            check("rst_last", out_last, 0);
            check("rst_data", out_data, 0);
            check("rst_stall", stall, 0);
            exp_q.delete();
            mdl_cnt  = 0;
            mdl_lidx = 0;
            mdl_ovf  = 1'b0;
        end else begin
            check("stall", stall, mdl_cnt >= STALL_TH);
            if (!out_valid) begin
                check("idle_data", out_data, 0);
                check("idle_last", out_last, 0);
            end
`ifdef LBREAD_OVF_EN
            check("overflow", overflow, mdl_ovf);
`endif
            if (flush) begin
                exp_q.delete();
                mdl_cnt  = 0;
                mdl_lidx = 0;
                mdl_ovf  = 1'b0;
            end else begin
                p = out_valid && out_ready;
                if (p) begin
                    n_pop++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL pop_empty: got data %0h expected no pixel", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("data", out_data, e);
                    end
                    check("last", out_last, mdl_lidx == LINE - 1);
                    mdl_lidx = (mdl_lidx + 1) % LINE;
                    mdl_cnt--;
                end
                if (in_valid) begin
                    if (mdl_cnt < DEPTH) begin
                        exp_q.push_back(in_data);
                        mdl_cnt++;
                    end else begin
                        mdl_ovf = 1'b1;
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = next_px;
            next_px  = next_px + 16'h1;
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge CLK);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int budget);
        int k;
        k = 0;
        while (!out_valid && k < budget) begin
            @(posedge CLK);
            #1;
            k++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: out_valid still 0 after %0d cycles, required 1", nm, budget);
        end
    endtask

    initial begin
        vecs[0] = '{7,  1'b0, 1'b0, 0};
        vecs[1] = '{8,  1'b0, 1'b1, 8};
        vecs[2] = '{13, 1'b0, 1'b1, 8};
        vecs[3] = '{14, 1'b1, 1'b1, 8};
        vecs[4] = '{16, 1'b1, 1'b1, 16};
        vecs[5] = '{17, 1'b1, 1'b1, 16};

        repeat (3) @(posedge CLK);
        #1;
        RESETN = 1'b1;
        idle(1);
        check("post_rst_state", fsm_state, 0);

        // First line: fall-through latency and ordering 0x0001..0x0008.
        n_pop = 0;
        out_ready = 1'b1;
        push_n(8);
        @(negedge CLK);
        check("lat_early", out_valid, 0);
        @(negedge CLK);
        check("lat_rise", out_valid, 1);
        @(posedge CLK);
        #1;
        idle(12);
        check("lat_npop", n_pop, 8);
        check("lat_state", fsm_state, 0);
        check("lat_valid", out_valid, 0);

        // Partial line waits indefinitely, completing pixel releases it.
        n_pop = 0;
        push_n(7);
        idle(20);
        check("part_valid", out_valid, 0);
        push_n(1);
        wait_valid("part_release", 5);
        idle(12);
        check("part_npop", n_pop, 8);
        do_flush();

        // Fill-level table with consumer held off, then drained.
        for (int i = 0; i < 6; i++) begin
            out_ready = 1'b0;
            push_n(vecs[i].n_push);
            idle(2);
            check("vec_stall", stall, vecs[i].exp_stall);
            check("vec_valid", out_valid, vecs[i].exp_valid);
            n_pop = 0;
            out_ready = 1'b1;
            idle(40);
            out_ready = 1'b0;
            check("vec_npop", n_pop, vecs[i].exp_out);
            do_flush();
        end

        // Stall release: 14 held, drain, top up the second line.
        n_pop = 0;
        out_ready = 1'b0;
        push_n(14);
        idle(1);
        check("stall_set", stall, 1);
        out_ready = 1'b1;
        idle(2);
        check("stall_drop", stall, 0);
        idle(12);
        push_n(2);
        idle(15);
        check("stall_npop", n_pop, 16);
        do_flush();

        // Full buffer with simultaneous push and pop.
        n_pop = 0;
        out_ready = 1'b0;
        push_n(16);
        idle(1);
        in_valid  = 1'b1;
        in_data   = next_px;
        next_px   = next_px + 16'h1;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        check("fullpp_stall", stall, 1);
        idle(30);
        check("fullpp_npop", n_pop, 16);
        out_ready = 1'b0;
        do_flush();

        // Flush after 3 of 8 pixels popped, then a clean line.
        push_n(8);
        wait_valid("fl_valid_wait", 5);
        out_ready = 1'b1;
        idle(3);
        out_ready = 1'b0;
        do_flush();
        check("fl_valid", out_valid, 0);
        check("fl_stall", stall, 0);
        n_pop = 0;
        out_ready = 1'b1;
        push_n(8);
        idle(12);
        check("fl_npop", n_pop, 8);

        // Reset pulse after 3 of 8 pixels popped, then a clean line.
        out_ready = 1'b0;
        push_n(8);
        wait_valid("rs_valid_wait", 5);
        out_ready = 1'b1;
        idle(3);
        out_ready = 1'b0;
        RESETN = 1'b0;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        RESETN = 1'b1;
        check("rs_valid", out_valid, 0);
        check("rs_state", fsm_state, 0);
        n_pop = 0;
        out_ready = 1'b1;
        push_n(8);
        idle(12);
        check("rs_npop", n_pop, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
